// File: rtl/trace_player.sv
`default_nettype none
// ============================================================================
// Module   : trace_player
// Brief    : Programmable timed-record player. Holds a list of value/delay
//            records and replays value changes onto NCH output channels,
//            with inter-record delays, single-shot or looping playback and
//            abort.
// Revision : 1.0 - initial release
// ============================================================================

module trace_player #(
  parameter  int NCH   = 12,
  parameter  int W     = 32,
  parameter  int DEPTH = 256,
  parameter  int CNT_W = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CHW   = $clog2(NCH),
  localparam int EW    = 1 + CHW + W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [EW-1:0]    wr_data,
  input  logic [AW:0]      len,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic [NCH*W-1:0] ch_data,
  output logic [NCH-1:0]   ch_upd,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    ptr,
  output logic             wr_err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Channel count widened by one bit so a power-of-two NCH still fits.
  localparam logic [CHW:0]   C_NCH       = (CHW+1)'(NCH);
  // Longest playable list; larger len requests are clamped to this.
  localparam logic [AW:0]    C_DEPTH_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0]    C_LEN_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]  C_PTR_ONE   = AW'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [EW-1:0]    mem_q [DEPTH];

  state_e           state_q,  state_d;
  logic [AW-1:0]    ptr_q,    ptr_d;
  logic [AW:0]      len_q,    len_d;
  logic             loop_q,   loop_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             done_q,   done_d;
  logic [NCH-1:0]   upd_q,    upd_d;
  logic [W-1:0]     ch_q [NCH];
  logic [W-1:0]     ch_d [NCH];
  logic             wr_err_q;

  // --------------------------------------------------------------------------
  // Record decode of the entry under the play pointer
  // --------------------------------------------------------------------------
  logic [EW-1:0]    w_rec;
  logic             w_kind;
  logic [CHW-1:0]   w_ch;
  logic [W-1:0]     w_pay;
  logic [CNT_W-1:0] w_n;
  logic             w_ch_ok;
  logic             w_last;
  logic             w_busy;
  logic             w_adv;

  assign w_rec   = mem_q[ptr_q];
  assign w_kind  = w_rec[EW-1];
  assign w_ch    = w_rec[W +: CHW];
  assign w_pay   = w_rec[W-1:0];
  assign w_n     = w_pay[CNT_W-1:0];
  assign w_ch_ok = ({1'b0, w_ch} < C_NCH);
  assign w_last  = ({1'b0, ptr_q} == (len_q - C_LEN_ONE));
  assign w_busy  = (state_q != ST_IDLE);

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy   = w_busy;
  assign done   = done_q;
  assign ptr    = ptr_q;
  assign ch_upd = upd_q;
  assign wr_err = wr_err_q;

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign ch_data[k*W +: W] = ch_q[k];
  end

  // Record memory: writes are only taken while the player is idle.
  always_ff @(posedge clk) begin
    if (wr_en && !w_busy) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Flag a write that arrives during playback (the write itself is dropped).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en && w_busy;
    end
  end

  // Next-state logic: record execution, delay countdown, list advance, abort.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    upd_d   = '0;
    ch_d    = ch_q;
    w_adv   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            // Empty list completes immediately.
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            ptr_d   = '0;
            len_d   = (len > C_DEPTH_LEN) ? C_DEPTH_LEN : len;
            loop_d  = loop;
          end
        end
      end

      ST_RUN: begin
        if (!w_kind) begin
          // Value record: out-of-range channels still cost one cycle.
          if (w_ch_ok) begin
            ch_d[w_ch]  = w_pay;
            upd_d[w_ch] = 1'b1;
          end
          w_adv = 1'b1;
        end else if (w_n <= C_CNT_ONE) begin
          w_adv = 1'b1;
        end else begin
          // This cycle counts as the first of N; WAIT covers the rest.
          state_d = ST_WAIT;
          cnt_d   = w_n - C_CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (cnt_q == C_CNT_ONE) begin
          w_adv = 1'b1;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_adv) begin
      if (!w_last) begin
        ptr_d   = ptr_q + C_PTR_ONE;
        state_d = ST_RUN;
      end else if (loop_q) begin
        // Wrap straight back to record 0 with no idle cycle.
        ptr_d   = '0;
        state_d = ST_RUN;
      end else begin
        ptr_d   = '0;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    // Abort wins over everything except reset; the aborted record has no effect.
    if (stop) begin
      state_d = ST_IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      upd_d   = '0;
      ch_d    = ch_q;
    end
  end

  // State register, including the channel value and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      upd_q   <= '0;
      for (int k = 0; k < NCH; k++) begin
        ch_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      upd_q   <= upd_d;
      for (int k = 0; k < NCH; k++) begin
        ch_q[k] <= ch_d[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trace_player.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_trace_player
// Brief    : Self-checking bench for trace_player. A record-list model expands
//            each playback into a per-cycle event queue and is compared with
//            the DUT on every cycle.
// Revision : 1.0 - initial release
// ============================================================================

module tb_trace_player;

  localparam int NCH   = 12;
  localparam int W     = 32;
  localparam int DEPTH = 256;
  localparam int CNT_W = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int CHW   = $clog2(NCH);
  localparam int EW    = 1 + CHW + W;

  typedef struct {
    int           ptr;
    int           ch;
    logic [W-1:0] val;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [EW-1:0]    wr_data = '0;
  logic [AW:0]      len = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_r = 1'b0;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_upd;
  logic             busy;
  logic             done;
  logic [AW-1:0]    ptr;
  logic             wr_err;

  int n_cmp = 0;
  int n_bad = 0;

  trace_player #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .stop(stop), .loop(loop_r),
    .ch_data(ch_data), .ch_upd(ch_upd), .busy(busy), .done(done),
    .ptr(ptr), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [NCH*W-1:0] act,
                       input logic [NCH*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [EW-1:0]  mem_m [DEPTH];
  logic [W-1:0]   ch_m [NCH];
  logic [NCH-1:0] upd_m = '0;
  bit             busy_m = 0, done_m = 0, werr_m = 0, loop_m = 0, model_ok = 0;
  int             ptr_m = 0, len_m = 0;
  ev_t            evq[$];

  // Unroll the list into one queue entry per clock cycle it occupies.
  function automatic void expand();
    evq.delete();
    for (int i = 0; i < len_m; i++) begin
      logic [EW-1:0] rec;
      int            n;
      ev_t           e;
      rec   = mem_m[i];
      e.ptr = i;
      e.ch  = -1;
      e.val = rec[W-1:0];
      if (rec[EW-1] == 1'b0) begin
        if (int'(rec[W +: CHW]) < NCH) e.ch = int'(rec[W +: CHW]);
        evq.push_back(e);
      end else begin
        n = int'(rec[CNT_W-1:0]);
        if (n < 1) n = 1;
        repeat (n) evq.push_back(e);
      end
    end
  endfunction

  initial begin
    ev_t e;
    bit  was_busy;
    for (int k = 0; k < NCH; k++) ch_m[k] = '0;
    forever begin
      @(posedge clk);
      was_busy = busy_m;
      upd_m  = '0;
      done_m = 0;
      werr_m = 0;
      if (rst) begin
        for (int k = 0; k < NCH; k++) ch_m[k] = '0;
        busy_m = 0;
        evq.delete();
      end else begin
        werr_m = wr_en && was_busy;
        if (wr_en && !was_busy) mem_m[wr_addr] = wr_data;
        if (stop) begin
          busy_m = 0;
          evq.delete();
        end else if (was_busy) begin
          e = evq.pop_front();
          if (e.ch >= 0) begin
            ch_m[e.ch]  = e.val;
            upd_m[e.ch] = 1'b1;
          end
          if (evq.size() == 0) begin
            if (loop_m) expand();
            else begin
              busy_m = 0;
              done_m = 1;
            end
          end
        end else if (start) begin
          if (len == '0) done_m = 1;
          else begin
            len_m  = (int'(len) > DEPTH) ? DEPTH : int'(len);
            loop_m = loop_r;
            expand();
            busy_m = 1;
          end
        end
      end
      ptr_m    = busy_m ? evq[0].ptr : 0;
      model_ok = 1;
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic [NCH*W-1:0] exp_data;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        for (int k = 0; k < NCH; k++) exp_data[k*W +: W] = ch_m[k];
        check("ch_data", ch_data, exp_data);
        check("ch_upd", ch_upd, upd_m);
        check("busy", busy, busy_m);
        check("done", done, done_m);
        check("ptr", ptr, ptr_m[AW-1:0]);
        check("wr_err", wr_err, werr_m);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [EW-1:0] mkval(input int ch, input logic [W-1:0] pay);
    logic [CHW-1:0] c;
    c = ch[CHW-1:0];
    return {1'b0, c, pay};
  endfunction

  function automatic logic [EW-1:0] mkdel(input int n);
    logic [W-1:0] pay;
    pay = W'($urandom);
    pay[CNT_W-1:0] = CNT_W'(n);
    return {1'b1, CHW'($urandom_range(0, 15)), pay};
  endfunction

  function automatic logic [EW-1:0] rnd_rec();
    if ($urandom_range(0, 2) == 0) return mkdel($urandom_range(0, 5));
    return mkval($urandom_range(0, 15), W'($urandom));
  endfunction

  task automatic wr(input int a, input logic [EW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic go(input int l, input bit lp);
    len    = (AW+1)'(l);
    loop_r = lp;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic run_to_done(input string nm, input int exp_cycles, input int bound);
    int cyc = 0;
    bit got = 0;
    for (int i = 0; i < bound; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (busy) cyc++;
      step();
    end
    check({nm, "_done"}, got, 1);
    check({nm, "_cycles"}, cyc, exp_cycles);
    if (!got) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
    end
  endtask

  logic [EW-1:0] tr[$];
  int            k_len;

  initial begin
    // Reset held for two edges.
    step();
    step();
    rst = 1'b0;
    check("rst_ch_data", ch_data, '0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ptr", ptr, 0);
    check("rst_ch_upd", ch_upd, 0);
    wr(0, mkval(0, 32'h1));
    check("idle_wr_err", wr_err, 0);

    // Fill the whole memory with value records.
    for (int i = 0; i < DEPTH; i++) wr(i, mkval($urandom_range(0, 11), W'($urandom)));

    // Basic replay: val ch0=1, delay 5, val ch10=DEADBEEF.
    wr(0, mkval(0, 32'h1));
    wr(1, mkdel(5));
    wr(2, mkval(10, 32'hDEADBEEF));
    go(3, 0);
    step();
    check("basic_upd0", ch_upd, 12'h001);
    check("basic_ch0", ch_data[0 +: W], 32'h1);
    check("basic_busy", busy, 1);
    repeat (5) step();
    check("basic_not_done", done, 0);
    step();
    check("basic_done", done, 1);
    check("basic_busy_low", busy, 0);
    check("basic_upd10", ch_upd, 12'h400);
    check("basic_ch10", ch_data[10*W +: W], 32'hDEADBEEF);

    // Loop: ch0 re-strobes 7 cycles later; stop inside the delay.
    go(3, 1);
    step();
    check("loop_upd0_a", ch_upd, 12'h001);
    repeat (7) step();
    check("loop_upd0_b", ch_upd, 12'h001);
    repeat (2) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("loop_stop_busy", busy, 0);
    check("loop_stop_done", done, 0);
    check("loop_stop_ch10", ch_data[10*W +: W], 32'hDEADBEEF);
    step();

    // Edges: delay 0, delay 1, invalid channel 13, val ch3.
    wr(0, mkdel(0));
    wr(1, mkdel(1));
    wr(2, mkval(13, 32'hBAD));
    wr(3, mkval(3, 32'h55));
    go(4, 0);
    repeat (3) step();
    check("edge_busy", busy, 1);
    check("edge_ch13_no_upd", ch_upd, 0);
    step();
    check("edge_done", done, 1);
    check("edge_upd3", ch_upd, 12'h008);

    // len = 0 completes at once.
    go(0, 0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    step();

    // len = 300 clamps to 256 single-cycle records.
    go(300, 0);
    run_to_done("len300", 256, 400);
    step();

    // Write while busy is dropped and flagged.
    wr(0, mkval(0, 32'h1));
    wr(1, mkdel(5));
    wr(2, mkval(10, 32'hDEADBEEF));
    go(3, 1);
    wr(1, mkval(5, 32'h1234));
    check("busy_wr_err", wr_err, 1);
    step();
    check("busy_wr_err_clr", wr_err, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    go(3, 0);
    run_to_done("after_drop", 7, 20);
    step();

    // Execution-bench style trace: clock on ch0 toggled by delay-1 records.
    tr.delete();
    for (int s = 0; s < 6; s++) begin
      tr.push_back(mkval(0, 32'h1));
      tr.push_back(mkval(1 + s, W'(s * 32'h111)));
      tr.push_back(mkdel(1));
      tr.push_back(mkval(0, 32'h0));
      tr.push_back(mkdel(1));
    end
    for (int i = 0; i < tr.size(); i++) wr(i, tr[i]);
    go(tr.size(), 0);
    run_to_done("trace", 30, 60);
    check("trace_ch0_final", ch_data[0 +: W], 32'h0);
    check("trace_ch6_final", ch_data[6*W +: W], 32'h555);
    step();

    // Randomized scenarios.
    for (int it = 0; it < 40; it++) begin
      k_len = $urandom_range(1, 16);
      for (int i = 0; i < k_len; i++) wr(i, rnd_rec());
      wr_en   = 1'b1;
      wr_addr = AW'($urandom_range(0, k_len - 1));
      wr_data = rnd_rec();
      go($urandom_range(0, k_len + 2), ($urandom_range(0, 3) == 0));
      wr_en = 1'b0;
      for (int c = 0; c < 60; c++) begin
        wr_en   = ($urandom_range(0, 7) == 0);
        wr_addr = AW'($urandom_range(0, 20));
        wr_data = rnd_rec();
        start   = ($urandom_range(0, 9) == 0);
        len     = (AW+1)'($urandom_range(0, 20));
        loop_r  = ($urandom_range(0, 3) == 0);
        stop    = ($urandom_range(0, 39) == 0);
        step();
      end
      wr_en = 1'b0;
      start = 1'b0;
      stop  = 1'b1;
      step();
      stop = 1'b0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
